// File: rtl/ksa_sched_pkg.sv
// rtl/ksa_sched_pkg.sv - shared types and round-robin pick for the KSA scheduler
package ksa_sched_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Lowest offset from ptr (with wrap) whose valid bit is set; 0 when none.
  function automatic int rr_pick(input logic [7:0] valid, input int ptr, input int n);
    int pick;
    pick = 0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n && valid[(ptr + k) % n]) pick = (ptr + k) % n;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ksa_mp_sched_if.sv
// rtl/ksa_mp_sched_if.sv - request/response bundle between requesters and the scheduler
interface ksa_mp_sched_if #(
  parameter int NREQ  = 2,
  parameter int WORDS = 4,
  parameter int IDW   = 1
);
  localparam int OW = 16 * WORDS;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OW-1:0]   req_a;
  logic [NREQ*OW-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [OW-1:0]        rsp_sum;
  logic                 rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/ksa16.sv
// rtl/ksa16.sv - 16-bit Kogge-Stone adder
module ksa16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic        Cout,
  output logic [15:0] Sum
);

  logic [4:0][15:0] gg;
  logic [4:0][15:0] pp;
  logic [16:0]      c;

  always_comb begin
    gg[0] = A & B;
    pp[0] = A ^ B;
    for (int l = 1; l < 5; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << (l - 1))) begin
          gg[l][i] = gg[l-1][i] | (pp[l-1][i] & gg[l-1][i - (1 << (l - 1))]);
          pp[l][i] = pp[l-1][i] & pp[l-1][i - (1 << (l - 1))];
        end else begin
          gg[l][i] = gg[l-1][i];
          pp[l][i] = pp[l-1][i];
        end
      end
    end
    // Group generate/propagate down to bit 0 fold in the incoming carry.
    c[0] = Cin;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = gg[4][i] | (pp[4][i] & Cin);
    end
    Sum  = pp[0] ^ c[15:0];
    Cout = c[16];
  end

endmodule

// File: rtl/ksa_rr_arb.sv
// rtl/ksa_rr_arb.sv - round-robin grant with pointer advanced past each accepted requester
module ksa_rr_arb
  import ksa_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  int             pick;

  always_comb begin
    pick      = rr_pick(8'(req_valid_i), int'(ptr_q), NREQ);
    gnt_any_o = |req_valid_i;
    gnt_o     = gnt_any_o ? (NREQ'(1) << pick) : '0;
    gnt_idx_o = IDW'(pick);
    ptr_d     = ptr_q;
    if (accept_i && gnt_any_o) ptr_d = IDW'((pick + 1) % NREQ);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ksa_mp_sched.sv
// rtl/ksa_mp_sched.sv - multi-precision add scheduler sharing one 16-bit KSA between requesters
module ksa_mp_sched
  import ksa_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WORDS = 4,
  parameter int IDW   = 1
) (
  input logic           clk,
  input logic           rst,
  ksa_mp_sched_if.slave bus
);

  localparam int OW = LIMB_W * WORDS;
  localparam int LW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                          state_q, state_d;
  logic [WORDS-1:0][LIMB_W-1:0]    a_q, a_d;
  logic [WORDS-1:0][LIMB_W-1:0]    b_q, b_d;
  logic [WORDS-1:0][LIMB_W-1:0]    sum_q, sum_d;
  logic                            carry_q, carry_d;
  logic                            cout_q, cout_d;
  logic [LW-1:0]                   limb_q, limb_d;
  logic [IDW-1:0]                  id_q, id_d;

  logic [NREQ-1:0][OW-1:0]         req_a_arr;
  logic [NREQ-1:0][OW-1:0]         req_b_arr;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0]                 gnt;
  logic [IDW-1:0]                  gnt_idx;
  logic                            gnt_any;
  logic [LIMB_W-1:0]               ksa_sum;
  logic                            ksa_cout;

  assign req_a_arr = bus.req_a;
  assign req_b_arr = bus.req_b;

  ksa_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (bus.req_valid),
    .accept_i    (state_q == IDLE),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_any_o   (gnt_any)
  );

  ksa16 u_ksa (
    .A    (a_q[limb_q]),
    .B    (b_q[limb_q]),
    .Cin  (carry_q),
    .Cout (ksa_cout),
    .Sum  (ksa_sum)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    limb_d    = limb_q;
    id_d      = id_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          a_d     = req_a_arr[gnt_idx];
          b_d     = req_b_arr[gnt_idx];
          carry_d = bus.req_cin[gnt_idx];
          id_d    = gnt_idx;
          limb_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[limb_q] = ksa_sum;
        carry_d       = ksa_cout;
        limb_d        = limb_q + LW'(1);
        if (limb_q == LW'(WORDS - 1)) begin
          cout_d  = ksa_cout;
          limb_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      limb_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      limb_q  <= limb_d;
      id_q    <= id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

endmodule

// File: tb/tb_ksa_mp_sched.sv
// tb/tb_ksa_mp_sched.sv - directed self-checking bench for ksa_mp_sched (NREQ=2, WORDS=4)
module tb_ksa_mp_sched;
  import ksa_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ksa_mp_sched_if #(.NREQ(2), .WORDS(4), .IDW(1)) bus ();

  ksa_mp_sched #(.NREQ(2), .WORDS(4), .IDW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [63:0] a, input logic [63:0] b, input logic cin);
    bus.req_valid[idx]       = 1'b1;
    bus.req_a[idx*64 +: 64]  = a;
    bus.req_b[idx*64 +: 64]  = b;
    bus.req_cin[idx]         = cin;
    #1;
    check("req_ready_grant", 64'(bus.req_ready), 64'(2'b01 << idx));
  endtask

  // Counts edges from the grant cycle until rsp_valid; releases the request after acceptance.
  task automatic wait_rsp(input int idx);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        bus.req_valid[idx] = 1'b0;
        check("req_ready_run", 64'(bus.req_ready), 64'd0);
      end
    end while (!bus.rsp_valid && n < 20);
    check("latency", 64'(n), 64'd5);
  endtask

  task automatic check_rsp(input logic [63:0] id, input logic [63:0] sum, input logic cout);
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_id",    64'(bus.rsp_id), id);
    check("rsp_sum",   bus.rsp_sum, sum);
    check("rsp_cout",  64'(bus.rsp_cout), 64'(cout));
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    check("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id), 64'd0);
    check("rst_rsp_sum",   bus.rsp_sum, 64'd0);
    check("rst_rsp_cout",  64'(bus.rsp_cout), 64'd0);

    // Limb carry, full ripple, top-limb overflow, mixed pattern
    issue(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_rsp(0);
    check_rsp(0, 64'h0000_0000_0001_0000, 1'b0);
    consume();

    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_rsp(1);
    check_rsp(1, 64'h0, 1'b1);
    consume();

    issue(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_rsp(0);
    check_rsp(0, 64'h0, 1'b1);
    consume();

    issue(1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    wait_rsp(1);
    check_rsp(1, 64'h2222_2222_2222_2212, 1'b0);
    consume();

    // Fairness: both requesters held valid across four transactions
    bus.req_a       = {64'd10, 64'd1};
    bus.req_b       = {64'd20, 64'd2};
    bus.req_cin     = '0;
    bus.req_valid   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!bus.rsp_valid && n < 30) begin
        tick();
        n++;
      end
      if (n >= 30) check("fair_timeout", 64'(n), 64'd0);
      if (t == 3) bus.req_valid = '0;
      check("fair_id",  64'(bus.rsp_id), 64'(t % 2));
      check("fair_sum", bus.rsp_sum, (t % 2) ? 64'd30 : 64'd3);
      tick();
    end

    // Backpressure: response held for 3 cycles while another requester waits
    bus.rsp_ready = 1'b0;
    issue(0, 64'h42, 64'h1, 1'b0);
    wait_rsp(0);
    bus.req_a[64 +: 64] = 64'h0;
    bus.req_b[64 +: 64] = 64'h0;
    bus.req_cin[1]      = 1'b0;
    bus.req_valid[1]    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid",     64'(bus.rsp_valid), 64'd1);
      check("bp_sum",       bus.rsp_sum, 64'h43);
      check("bp_id",        64'(bus.rsp_id), 64'd0);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_hs_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    check("bp_after_valid",  64'(bus.rsp_valid), 64'd0);
    check("bp_next_grant",   64'(bus.req_ready), 64'd2);
    wait_rsp(1);
    check_rsp(1, 64'h0, 1'b0);
    consume();

    // Reset while limb==2 aborts the transaction
    issue(0, 64'd100, 64'd200, 1'b0);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    tick();
    check("abort_limb", 64'(dut.limb_q), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort_state",     64'(dut.state_q), 64'(IDLE));
    check("abort_ptr",       64'(dut.u_arb.ptr_q), 64'd0);
    check("abort_sum",       bus.rsp_sum, 64'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.rsp_valid) seen++;
      tick();
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    issue(1, 64'd5, 64'd7, 1'b0);
    wait_rsp(1);
    check_rsp(1, 64'd12, 1'b0);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
